// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: CPU memory-port strobes, Avalon-MM master signals and error controls of the bridge.
interface mem_bus_bridge_if;
  logic [15:0] i_cpu_addr;
  logic        i_cpu_rd;
  logic        i_cpu_wr;
  logic [15:0] i_cpu_wrdata;
  logic [15:0] o_cpu_rddata;
  logic        o_cpu_rddata_valid;
  logic        o_cpu_wr_done;
  logic        o_cpu_busy;
  logic [15:0] o_avm_address;
  logic        o_avm_read;
  logic        o_avm_write;
  logic [15:0] o_avm_writedata;
  logic [15:0] i_avm_readdata;
  logic        i_avm_waitrequest;
  logic        i_avm_readdatavalid;
  logic        i_err_clr;
  logic [2:0]  o_err;
  modport slave (
    input  i_cpu_addr, i_cpu_rd, i_cpu_wr, i_cpu_wrdata,
    input  i_avm_readdata, i_avm_waitrequest, i_avm_readdatavalid, i_err_clr,
    output o_cpu_rddata, o_cpu_rddata_valid, o_cpu_wr_done, o_cpu_busy,
    output o_avm_address, o_avm_read, o_avm_write, o_avm_writedata, o_err
  );
  modport master (
    output i_cpu_addr, i_cpu_rd, i_cpu_wr, i_cpu_wrdata,
    output i_avm_readdata, i_avm_waitrequest, i_avm_readdatavalid, i_err_clr,
    input  o_cpu_rddata, o_cpu_rddata_valid, o_cpu_wr_done, o_cpu_busy,
    input  o_avm_address, o_avm_read, o_avm_write, o_avm_writedata, o_err
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns single-cycle CPU rd/wr strobes into held Avalon-MM pipelined requests,
// with read-data return, busy stall, per-phase timeout and sticky error flags.
module mem_bus_bridge #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input logic            clk,
  input logic            reset,
  mem_bus_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d, wdata_q, wdata_d, rddata_q, rddata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d, err_set;
  logic             is_rd_q, is_rd_d, mis_wr_q, mis_wr_d, tmo, strobe;
  assign strobe = bus.i_cpu_rd | bus.i_cpu_wr;
  assign tmo    = (TIMEOUT != 0) && (cnt_q == TMAX);
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rddata_d = rddata_q;
    is_rd_d  = is_rd_q;
    mis_wr_d = 1'b0;
    err_set  = '0;
    case (state_q)
      IDLE:
        if (bus.i_cpu_rd && bus.i_cpu_wr) err_set[1] = 1'b1;
        else if (strobe && bus.i_cpu_addr[0]) begin
          err_set[0] = 1'b1;
          mis_wr_d   = bus.i_cpu_wr;
        end else if (strobe) begin
          addr_d  = bus.i_cpu_addr;
          wdata_d = bus.i_cpu_wr ? bus.i_cpu_wrdata : wdata_q;
          is_rd_d = bus.i_cpu_rd;
          state_d = bus.i_cpu_rd ? RD_REQ : WR_REQ;
        end
      RD_REQ:
        if (!bus.i_avm_waitrequest) state_d = RD_WAIT;
        else if (tmo) begin
          state_d    = RESP;
          rddata_d   = '0;
          err_set[2] = 1'b1;
        end
      RD_WAIT:
        if (bus.i_avm_readdatavalid) begin
          state_d  = RESP;
          rddata_d = bus.i_avm_readdata;
        end else if (tmo) begin
          state_d    = RESP;
          rddata_d   = '0;
          err_set[2] = 1'b1;
        end
      WR_REQ:
        if (!bus.i_avm_waitrequest) state_d = RESP;
        else if (tmo) begin
          state_d    = RESP;
          err_set[2] = 1'b1;
        end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && strobe) err_set[1] = 1'b1;
    err_d = (bus.i_err_clr ? 3'b000 : err_q) | err_set;
    // counter restarts on every state entry, so each bus phase gets its own budget
    cnt_d = (state_d == state_q && state_q != IDLE) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rddata_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      is_rd_q  <= 1'b0;
      mis_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rddata_q <= rddata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      is_rd_q  <= is_rd_d;
      mis_wr_q <= mis_wr_d;
    end
  assign bus.o_cpu_rddata       = rddata_q;
  assign bus.o_cpu_rddata_valid = state_q == RESP && is_rd_q;
  assign bus.o_cpu_wr_done      = (state_q == RESP && !is_rd_q) || mis_wr_q;
  assign bus.o_cpu_busy         = state_q != IDLE;
  assign bus.o_avm_address      = addr_q;
  assign bus.o_avm_read         = state_q == RD_REQ;
  assign bus.o_avm_write        = state_q == WR_REQ;
  assign bus.o_avm_writedata    = wdata_q;
  assign bus.o_err              = err_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: scenario tasks drive the CPU/Avalon sides; read data and write completions
// are checked against a scoreboard queue by a negedge monitor.
module tb_mem_bus_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_rd[$];
  logic        exp_wr[$];
  mem_bus_bridge_if bus();
  mem_bus_bridge #(.TIMEOUT(8), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_cpu_rddata_valid) begin
      tests++;
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL sb_rd_unexpected: valid pulse with rddata %h, none expected", bus.o_cpu_rddata);
      end else begin
        logic [15:0] e;
        e = exp_rd.pop_front();
        if (bus.o_cpu_rddata !== e) begin
          fails++;
          $display("FAIL sb_rddata: got %h expected %h", bus.o_cpu_rddata, e);
        end
      end
    end
    if (bus.o_cpu_wr_done) begin
      tests++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL sb_wr_unexpected: wr_done pulse with none expected");
      end else void'(exp_wr.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick();
    if ({bus.o_cpu_rddata, bus.o_cpu_rddata_valid, bus.o_cpu_wr_done, bus.o_cpu_busy, bus.o_avm_address,
         bus.o_avm_read, bus.o_avm_write, bus.o_avm_writedata, bus.o_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: some output nonzero, err=%b busy=%b", bus.o_err, bus.o_cpu_busy);
    end
    tests++;
    reset = 1'b1;
    tick();
    chk("reset_idle", {31'd0, bus.o_cpu_busy}, 32'd0);
  endtask

  task automatic test_read();
    bus.i_cpu_addr = 16'h0010; bus.i_cpu_rd = 1'b1;
    exp_rd.push_back(16'h1234);
    chk("rd_pre_read", {31'd0, bus.o_avm_read}, 32'd0);
    tick();
    bus.i_cpu_rd = 1'b0; bus.i_cpu_addr = 16'hFFFE;
    chk("rd_n1_read", {31'd0, bus.o_avm_read}, 32'd1);
    chk("rd_n1_addr", {16'd0, bus.o_avm_address}, 32'h0010);
    chk("rd_n1_busy", {31'd0, bus.o_cpu_busy}, 32'd1);
    tick();
    chk("rd_n2_read", {31'd0, bus.o_avm_read}, 32'd0);
    bus.i_avm_readdatavalid = 1'b1; bus.i_avm_readdata = 16'h1234;
    tick();
    bus.i_avm_readdatavalid = 1'b0; bus.i_avm_readdata = 16'h0;
    chk("rd_n3_valid", {31'd0, bus.o_cpu_rddata_valid}, 32'd1);
    chk("rd_n3_data", {16'd0, bus.o_cpu_rddata}, 32'h1234);
    tick();
    chk("rd_n4_idle", {30'd0, bus.o_cpu_busy, bus.o_cpu_rddata_valid}, 32'd0);
    chk("rd_hold_data", {16'd0, bus.o_cpu_rddata}, 32'h1234);
  endtask

  task automatic test_write();
    bus.i_cpu_addr = 16'h0020; bus.i_cpu_wrdata = 16'hBEEF; bus.i_cpu_wr = 1'b1;
    bus.i_avm_waitrequest = 1'b1;
    exp_wr.push_back(1'b1);
    tick();
    bus.i_cpu_wr = 1'b0; bus.i_cpu_addr = 16'h5554; bus.i_cpu_wrdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      chk("wr_held", {31'd0, bus.o_avm_write}, 32'd1);
      chk("wr_stable", {bus.o_avm_address, bus.o_avm_writedata}, 32'h0020BEEF);
      chk("wr_no_done", {31'd0, bus.o_cpu_wr_done}, 32'd0);
      if (i == 3) bus.i_avm_waitrequest = 1'b0;
      tick();
    end
    chk("wr_dropped", {31'd0, bus.o_avm_write}, 32'd0);
    chk("wr_done", {30'd0, bus.o_cpu_wr_done, bus.o_cpu_busy}, 32'd3);
    tick();
    chk("wr_idle", {30'd0, bus.o_cpu_wr_done, bus.o_cpu_busy}, 32'd0);
  endtask

  task automatic test_misaligned();
    bus.i_cpu_addr = 16'h0011; bus.i_cpu_rd = 1'b1;
    tick();
    bus.i_cpu_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mis_rd_nobus", {30'd0, bus.o_avm_read, bus.o_cpu_busy}, 32'd0);
      tick();
    end
    chk("mis_rd_err", {29'd0, bus.o_err}, 32'b001);
    bus.i_cpu_addr = 16'h0013; bus.i_cpu_wr = 1'b1;
    exp_wr.push_back(1'b1);
    tick();
    bus.i_cpu_wr = 1'b0;
    chk("mis_wr_done", {29'd0, bus.o_cpu_wr_done, bus.o_cpu_busy, bus.o_avm_write}, 32'b100);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
    chk("err_clr", {29'd0, bus.o_err}, 32'd0);
    bus.i_err_clr = 1'b1; bus.i_cpu_rd = 1'b1; bus.i_cpu_addr = 16'h0015;
    tick();
    bus.i_err_clr = 1'b0; bus.i_cpu_rd = 1'b0;
    chk("err_clr_newwins", {29'd0, bus.o_err}, 32'b001);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bus.i_avm_waitrequest = 1'b1; bus.i_cpu_addr = 16'h0040; bus.i_cpu_rd = 1'b1;
    exp_rd.push_back(16'h0000);
    tick();
    bus.i_cpu_rd = 1'b0;
    n = 0;
    while (bus.o_avm_read && n < 20) begin n++; tick(); end
    chk("tmo_rd_cycles", n, 8);
    chk("tmo_rd_valid", {31'd0, bus.o_cpu_rddata_valid}, 32'd1);
    chk("tmo_rd_data", {16'd0, bus.o_cpu_rddata}, 32'h0000);
    chk("tmo_rd_err", {29'd0, bus.o_err}, 32'b100);
    bus.i_avm_waitrequest = 1'b0; bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
    bus.i_avm_waitrequest = 1'b1; bus.i_cpu_addr = 16'h0042; bus.i_cpu_wrdata = 16'h7777; bus.i_cpu_wr = 1'b1;
    exp_wr.push_back(1'b1);
    tick();
    bus.i_cpu_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bus.i_avm_waitrequest = 1'b0;
      chk("edge_wr_held", {31'd0, bus.o_avm_write}, 32'd1);
      tick();
    end
    chk("edge_wr_done", {31'd0, bus.o_cpu_wr_done}, 32'd1);
    chk("edge_wr_noerr", {29'd0, bus.o_err}, 32'd0);
    tick();
    bus.i_cpu_addr = 16'h0044; bus.i_cpu_rd = 1'b1;
    exp_rd.push_back(16'h0000);
    tick();
    bus.i_cpu_rd = 1'b0;
    n = 0;
    while (!bus.o_cpu_rddata_valid && n < 20) begin n++; tick(); end
    chk("tmo_rdwait_cycles", n, 9);
    chk("tmo_rdwait_err", {29'd0, bus.o_err}, 32'b100);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
  endtask

  task automatic test_overrun();
    bus.i_cpu_addr = 16'h0050; bus.i_cpu_rd = 1'b1;
    exp_rd.push_back(16'hA5A5);
    tick();
    bus.i_cpu_rd = 1'b0;
    tick();
    bus.i_cpu_rd = 1'b1; bus.i_cpu_addr = 16'h0052;
    tick();
    bus.i_cpu_rd = 1'b0;
    chk("ovr_err", {29'd0, bus.o_err}, 32'b010);
    chk("ovr_still_wait", {30'd0, bus.o_cpu_busy, bus.o_avm_read}, 32'b10);
    bus.i_avm_readdatavalid = 1'b1; bus.i_avm_readdata = 16'hA5A5;
    tick();
    bus.i_avm_readdatavalid = 1'b0;
    chk("ovr_first_done", {15'd0, bus.o_cpu_rddata_valid, bus.o_cpu_rddata}, 32'h1A5A5);
    tick();
    chk("ovr_no_second", {30'd0, bus.o_cpu_busy, bus.o_avm_read}, 32'd0);
    bus.i_cpu_rd = 1'b1; bus.i_cpu_wr = 1'b1; bus.i_err_clr = 1'b1;
    tick();
    bus.i_cpu_rd = 1'b0; bus.i_cpu_wr = 1'b0; bus.i_err_clr = 1'b0;
    chk("both_err", {29'd0, bus.o_err}, 32'b010);
    chk("both_ignored", {29'd0, bus.o_cpu_busy, bus.o_avm_read, bus.o_avm_write}, 32'd0);
    bus.i_avm_waitrequest = 1'b1; bus.i_cpu_addr = 16'h0060; bus.i_cpu_wrdata = 16'h1111; bus.i_cpu_wr = 1'b1;
    tick();
    bus.i_cpu_wr = 1'b0;
    chk("rst_pre_write", {31'd0, bus.o_avm_write}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async", {bus.o_cpu_rddata, 6'd0, bus.o_cpu_rddata_valid, bus.o_cpu_wr_done, bus.o_cpu_busy,
                      bus.o_avm_read, bus.o_avm_write, bus.o_err}, 32'd0);
    chk("rst_bus", {bus.o_avm_address, bus.o_avm_writedata}, 32'd0);
    tick();
    reset = 1'b1; bus.i_avm_waitrequest = 1'b0;
    tick();
    chk("rst_idle", {30'd0, bus.o_cpu_busy, bus.o_avm_write}, 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] d);
    bus.i_cpu_addr = a; bus.i_cpu_rd = 1'b1;
    exp_rd.push_back(d);
    tick();
    bus.i_cpu_rd = 1'b0;
    chk("b2b_rd_addr", {15'd0, bus.o_avm_read, bus.o_avm_address}, {15'd0, 1'b1, a});
    tick();
    bus.i_avm_readdatavalid = 1'b1; bus.i_avm_readdata = d;
    tick();
    bus.i_avm_readdatavalid = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bus.i_cpu_addr = a; bus.i_cpu_wrdata = d; bus.i_cpu_wr = 1'b1;
    exp_wr.push_back(1'b1);
    tick();
    bus.i_cpu_wr = 1'b0;
    chk("b2b_wr_bus", {bus.o_avm_address, bus.o_avm_writedata}, {a, d});
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_read(16'h0100, 16'hC0DE);
    do_write(16'h0102, 16'h4242);
    do_read(16'h0104, 16'h0F0F);
    do_read(16'h0106, 16'hFFFF);
    do_write(16'hFFFE, 16'h8001);
    chk("b2b_err_clean", {29'd0, bus.o_err}, 32'd0);
  endtask

  initial begin
    bus.i_cpu_addr = '0; bus.i_cpu_rd = 1'b0; bus.i_cpu_wr = 1'b0; bus.i_cpu_wrdata = '0;
    bus.i_avm_readdata = '0; bus.i_avm_waitrequest = 1'b0; bus.i_avm_readdatavalid = 1'b0; bus.i_err_clr = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_timeout();
    test_overrun();
    test_back_to_back();
    tick();
    chk("sb_drained", exp_rd.size() + exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
